div_multicycle: RTL and testbench

//  Sequential radix-2 restoring divider implementing MIPS DIV/DIVU.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/div_multicycle.sv | 116 +++++++++++
 tb/tb_div_multicycle.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle restoring divider: FSM states and divide-by-zero constant.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Wide enough for any supported WIDTH; users slice off the low WIDTH bits.
  localparam int unsigned DIV_MAX_WIDTH = 128;
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    // rem is always below divisor, so rem[WIDTH] never sets; folding it in keeps the full width meaningful
    fits     = rem[WIDTH] | (shifted >= {1'b0, divisor});
    rem_next = fits ? (shifted - {1'b0, divisor}) : shifted;
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_multicycle.sv
// Sequential radix-2 restoring divider for MIPS DIV/DIVU; WIDTH+1 cycles from start to done.
// Optional DIV_ZERO_FLAG_EN adds a registered div_zero output.
module div_multicycle
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  div_state_e     state, state_n;
  logic [CW-1:0]  count;
  logic [WIDTH:0] rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next, dvs;
  logic q_neg, r_neg, dz;
  logic [WIDTH-1:0] dividend_abs, divisor_abs, q_fixed, r_fixed;
  logic last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    last_step    = (count == CW'(WIDTH-1));
    q_fixed      = dz ? DIV_ZERO_QUOT[WIDTH-1:0] : (q_neg ? -quo : quo);
    // On divide-by-zero rem ends as |dividend|, so re-applying the sign restores the original dividend
    r_fixed      = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last_step) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            quo   <= dividend_abs;
            dvs   <= divisor_abs;
            q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed & dividend[WIDTH-1];
            dz    <= (divisor == '0);
            count <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CW'(1);
        end
        FIX: begin
          quotient  <= q_fixed;
          remainder <= r_fixed;
          done      <= 1'b1;
          busy      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero  <= dz;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_multicycle.sv
// Self-checking bench for div_multicycle: directed corner cases plus randomized operands against an arithmetic model.
module tb_div_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  int n_checks = 0;
  int n_fail = 0;

  div_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU from plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, sq, sr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[W-1:0];
      r = sr[W-1:0];
    end
  endfunction

  // Called between edges; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  // Waits for done, checking latency, busy, results; optionally pulses a stray start at cycle poke.
  task automatic wait_done(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int poke);
    int  n = 0;
    logic busy_bad = 1'b0;
    while (n < 100) begin
      if (poke != 0 && n == poke) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) break;
      if (!busy) busy_bad = 1'b1;
    end
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_busy_in_flight"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, "_div_zero"}, div_zero, ez);
`else
    if (ez) begin end
`endif
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] eq, input logic [W-1:0] er);
    launch(a, b, s);
    wait_done(tag, eq, er, b == '0, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         s;
    logic         saw_done;

    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quotient, 0);
    check("reset_rem", remainder, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    run("divu_zero", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    run("div_zero", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    run("div_zero_neg", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00);
    run("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);

    // Stray start 10 cycles in must be ignored
    launch(32'd1000, 32'd33, 1'b0);
    wait_done("ignored_start", 32'd30, 32'd10, 1'b0, 10);

    // Back-to-back: new start during the done cycle
    launch(32'hFFFF_FF9C, 32'd9, 1'b1);
    check("b2b_hold_quot", quotient, 32'd30);
    check("b2b_hold_rem", remainder, 32'd10);
    wait_done("back_to_back", 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0, 0);

    // Reset mid-CALC
    @(posedge clk);
    #1;
    launch(32'd555, 32'd5, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quot", quotient, 0);
    check("midrst_rem", remainder, 0);
    #2 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_activity", saw_done, 0);
    run("after_reset", 32'd555, 32'd5, 1'b0, 32'd111, 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      model(a, b, s, eq, er);
      run($sformatf("rand%0d", i), a, b, s, eq, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got time-out expected completion");
    $fatal(1, "timeout");
  end

endmodule
